// File: rtl/dcache_2way_wb.sv
// Two-way set-associative write-back, write-allocate data cache.
// Misses evict dirty victims word by word, then fill over a req/ack port.
module dcache_2way_wb #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 1;
    localparam int SETS  = 1 << INDEX_W;
    localparam int N     = 1 << OFFSET_W;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;
    state_t r_state, w_nstate;

    logic [DATA_W-1:0]    r_data [2][SETS][N];
    logic [TAG_W-1:0]     r_tag  [2][SETS];
    logic [SETS-1:0][1:0] r_valid;
    logic [SETS-1:0][1:0] r_dirty;
    logic [SETS-1:0]      r_mru;

    logic                 r_vway;
    logic [INDEX_W-1:0]   r_idx;
    logic [TAG_W-1:0]     r_vtag;
    logic [TAG_W-1:0]     r_rtag;
    logic [OFFSET_W-1:0]  r_cnt;

    logic [OFFSET_W-1:0]  w_off;
    logic [INDEX_W-1:0]   w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit0, w_hit1, w_hit, w_hway;
    logic                 w_vict, w_vdirty, w_idle;
    logic                 w_hit_acc, w_miss, w_last;
    logic                 w_ack_wb, w_ack_fill;
    logic                 w_unused;

    assign w_off  = cpu_addr[OFFSET_W:1];
    assign w_idx  = cpu_addr[OFFSET_W+INDEX_W:OFFSET_W+1];
    assign w_tag  = cpu_addr[ADDR_W-1:ADDR_W-TAG_W];
    assign w_unused = cpu_addr[0];

    assign w_hit0 = r_valid[w_idx][0] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1 = r_valid[w_idx][1] && (r_tag[1][w_idx] == w_tag);
    assign w_hit  = w_hit0 | w_hit1;
    assign w_hway = ~w_hit0;

    // Prefer an empty way, otherwise replace the least recently used one
    assign w_vict = !r_valid[w_idx][0] ? 1'b0 :
                    !r_valid[w_idx][1] ? 1'b1 : ~r_mru[w_idx];
    assign w_vdirty = r_valid[w_idx][w_vict] & r_dirty[w_idx][w_vict];

    assign w_idle     = (r_state == S_IDLE);
    assign w_hit_acc  = w_idle & cpu_req & w_hit;
    assign w_miss     = w_idle & cpu_req & ~w_hit;
    assign w_last     = (r_cnt == {OFFSET_W{1'b1}});
    assign w_ack_wb   = (r_state == S_WB) & mem_ack;
    assign w_ack_fill = (r_state == S_FILL) & mem_ack;

    assign cpu_stall = ~w_idle | (cpu_req & ~w_hit);
    assign cpu_rdata = r_data[w_hway][w_idx][w_off];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate  = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_miss) w_nstate = w_vdirty ? S_WB : S_FILL;
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_vtag, r_idx, r_cnt, 1'b0};
                mem_wdata = r_data[r_vway][r_idx][r_cnt];
                if (mem_ack && w_last) w_nstate = S_FILL;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_rtag, r_idx, r_cnt, 1'b0};
                if (mem_ack && w_last) w_nstate = S_IDLE;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_mru   <= '0;
            r_vway  <= 1'b0;
            r_idx   <= '0;
            r_vtag  <= '0;
            r_rtag  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_hit_acc) begin
                r_mru[w_idx] <= w_hway;
                if (cpu_we) r_dirty[w_idx][w_hway] <= 1'b1;
            end
            if (w_miss) begin
                r_vway <= w_vict;
                r_idx  <= w_idx;
                r_vtag <= r_tag[w_vict][w_idx];
                r_rtag <= w_tag;
                r_cnt  <= '0;
                if (!w_vdirty) r_valid[w_idx][w_vict] <= 1'b0;
            end
            if (w_ack_wb || w_ack_fill) r_cnt <= r_cnt + OFFSET_W'(1);
            // Line is invalid while it is being refilled
            if (w_ack_wb && w_last) r_valid[r_idx][r_vway] <= 1'b0;
            if (w_ack_fill && w_last) begin
                r_valid[r_idx][r_vway] <= 1'b1;
                r_dirty[r_idx][r_vway] <= 1'b0;
                r_mru[r_idx]           <= r_vway;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hit_acc && cpu_we) r_data[w_hway][w_idx][w_off] <= cpu_wdata;
        if (w_ack_fill) begin
            r_data[r_vway][r_idx][r_cnt] <= mem_rdata;
            if (w_last) r_tag[r_vway][r_idx] <= r_rtag;
        end
    end
endmodule
